// File: rtl/nq_pkg.sv
// Shared encodings for the nq core: instruction formats, memory opcodes,
// store byte-lane selects and the memory access unit state type.
package nq_pkg;

    typedef enum logic [1:0] {
        FMT_RTYPE,
        FMT_ITYPE,
        FMT_JTYPE,
        FMT_BTYPE
    } instrFmt_e;

    localparam logic [3:0] OP_LUI = 4'b1000;
    localparam logic [3:0] OP_LBI = 4'b1001;
    localparam logic [3:0] OP_SUI = 4'b1010;
    localparam logic [3:0] OP_SBI = 4'b1011;
    localparam logic [3:0] OP_LW  = 4'b1100;
    localparam logic [3:0] OP_SW  = 4'b1101;

    localparam logic [1:0] BSEL_WORD = 2'b11;
    localparam logic [1:0] BSEL_HI   = 2'b10;
    localparam logic [1:0] BSEL_LO   = 2'b01;
    localparam logic [1:0] BSEL_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } memState_e;

    // A store that writes no lanes is rejected together with a load+store clash.
    function automatic logic isLegalReq(input logic rd, input logic wr, input logic [1:0] bsel);
        return (rd ^ wr) && !(wr && (bsel == BSEL_NONE));
    endfunction

endpackage

// File: rtl/mem_tmo_counter.sv
// Watchdog counter for the memory bus wait: counts enabled cycles since the
// last clear and flags the cycle in which the LIMIT-th cycle is reached.
module mem_tmo_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturates at LAST so a held enable never wraps back to an early value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired_o = enable_i && !clear_i && (count_q == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer driving a req/ack data-memory bus and the
// pipeline stall. Define MEM_TIMEOUT_EN to add a watchdog on the bus wait.
module mem_access_unit
    import nq_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int TMO_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          memRd_flg,
    input  logic          memWrt_flg,
    input  logic [1:0]    byte_sel,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rd_valid,
    output logic          stall_flg,
    output logic          acc_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_be,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    memState_e     state_q;
    logic          isLoad_q;
    logic          memReq_q;
    logic          memWe_q;
    logic [AW-1:0] memAddr_q;
    logic [DW-1:0] memWdata_q;
    logic [1:0]    memBe_q;
    logic [DW-1:0] rdata_q;
    logic          rdValid_q;
    logic          accErr_q;

    logic legalReq;
    logic illegalReq;
    logic tmoExpired;

    assign legalReq   = isLegalReq(memRd_flg, memWrt_flg, byte_sel);
    assign illegalReq = (memRd_flg | memWrt_flg) & ~legalReq;

`ifdef MEM_TIMEOUT_EN
    // Held clear outside BUS, so every bus access starts counting from zero.
    mem_tmo_counter #(
        .LIMIT(TMO_CYCLES)
    ) u_tmo (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .clear_i  (state_q != ST_BUS),
        .enable_i ((state_q == ST_BUS) && !mem_ack),
        .expired_o(tmoExpired)
    );
`else
    logic unusedTmo;
    assign unusedTmo  = (TMO_CYCLES == 0);
    assign tmoExpired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            isLoad_q   <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memBe_q    <= '0;
            rdata_q    <= '0;
            rdValid_q  <= 1'b0;
            accErr_q   <= 1'b0;
        end else begin
            rdValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (legalReq) begin
                        memAddr_q  <= addr;
                        memWdata_q <= wdata;
                        memBe_q    <= memRd_flg ? BSEL_WORD : byte_sel;
                        memReq_q   <= 1'b1;
                        memWe_q    <= memWrt_flg;
                        isLoad_q   <= memRd_flg;
                        state_q    <= ST_BUS;
                    end else if (illegalReq) begin
                        accErr_q <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (mem_ack) begin
                        memReq_q <= 1'b0;
                        memWe_q  <= 1'b0;
                        if (isLoad_q) begin
                            rdata_q   <= mem_rdata;
                            rdValid_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end else if (tmoExpired) begin
                        memReq_q <= 1'b0;
                        memWe_q  <= 1'b0;
                        accErr_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                // Flags seen here still belong to the retiring instruction.
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_flg = rst_n & (((state_q == ST_IDLE) & legalReq) | (state_q == ST_BUS));

    assign rdata     = rdata_q;
    assign rd_valid  = rdValid_q;
    assign acc_err   = accErr_q;
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_be    = memBe_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues loads/stores against a
// word-level memory model, a bus responder acks, and a monitor checks the bus.
module tb_mem_access_unit;

    localparam int TMO = 8;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } busExp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memRd_flg = 1'b0;
    logic        memWrt_flg = 1'b0;
    logic [1:0]  byte_sel = 2'b00;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        rd_valid;
    logic        stall_flg;
    logic        acc_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    int testsRun = 0;
    int testsFailed = 0;

    busExp_t     busQ[$];
    logic [15:0] rdQ[$];
    logic [15:0] refMem[logic [15:0]];
    logic [15:0] busMem[logic [15:0]];
    logic        expErr = 1'b0;
    logic [15:0] expRdata = 16'h0;
    bit          manualBus = 1'b0;
    int          nextWait = 0;
    int          strayReq = 0;

    mem_access_unit #(
        .AW(16),
        .DW(16),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRd_flg (memRd_flg),
        .memWrt_flg(memWrt_flg),
        .byte_sel  (byte_sel),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rd_valid  (rd_valid),
        .stall_flg (stall_flg),
        .acc_err   (acc_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : 16'h0;
    endfunction

    function automatic logic [15:0] busRead(input logic [15:0] a);
        return busMem.exists(a) ? busMem[a] : 16'h0;
    endfunction

    // Word-level view of a store: sui keeps the low byte, sbi keeps the high byte.
    task automatic refWrite(input logic [15:0] a, input logic [15:0] d, input logic [1:0] bs);
        logic [15:0] old;
        old = refRead(a);
        case (bs)
            2'b11:   refMem[a] = d;
            2'b10:   refMem[a] = {d[15:8], old[7:0]};
            2'b01:   refMem[a] = {old[15:8], d[7:0]};
            default: refMem[a] = old;
        endcase
    endtask

    // Bus-side memory: acks after nextWait idle cycles, or once per stray request.
    initial begin : responder
        bit          active;
        int          remaining;
        int          strayDone;
        logic [15:0] cur;
        active = 1'b0;
        remaining = 0;
        strayDone = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (strayReq > strayDone) begin
                strayDone++;
                mem_ack = 1'b1;
            end else if (mem_req === 1'b1 && !manualBus) begin
                if (!active) begin
                    active = 1'b1;
                    remaining = nextWait;
                end
                if (remaining == 0) begin
                    mem_ack = 1'b1;
                    active = 1'b0;
                    if (mem_we === 1'b1) begin
                        cur = busRead(mem_addr);
                        for (int lane = 0; lane < 2; lane++) begin
                            if (mem_be[lane]) cur[lane*8 +: 8] = mem_wdata[lane*8 +: 8];
                        end
                        busMem[mem_addr] = cur;
                    end else begin
                        mem_rdata = busRead(mem_addr);
                    end
                end else begin
                    remaining--;
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    // Pops one expected bus transaction per mem_req rise and one load result per rd_valid.
    initial begin : monitor
        bit      prevReq;
        logic    stable;
        busExp_t cur;
        prevReq = 1'b0;
        cur.we = 1'b0;
        cur.addr = 16'h0;
        cur.wdata = 16'h0;
        cur.be = 2'b00;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && !prevReq) begin
                if (busQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL bus_unexpected: got request at addr %0h, expected no request", mem_addr);
                    cur.we = mem_we;
                    cur.addr = mem_addr;
                    cur.wdata = mem_wdata;
                    cur.be = mem_be;
                end else begin
                    cur = busQ.pop_front();
                    checkOutput("bus_we", 32'(mem_we), 32'(cur.we));
                    checkOutput("bus_addr", 32'(mem_addr), 32'(cur.addr));
                    checkOutput("bus_be", 32'(mem_be), 32'(cur.be));
                    if (cur.we) checkOutput("bus_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
            end else if (mem_req === 1'b1) begin
                stable = (mem_addr === cur.addr) && (mem_be === cur.be) && (mem_we === cur.we)
                         && (!cur.we || (mem_wdata === cur.wdata));
                checkOutput("bus_stable", 32'(stable), 32'(1));
            end
            prevReq = (mem_req === 1'b1);
            if (rd_valid === 1'b1) begin
                if (rdQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL rd_unexpected: got rd_valid with rdata %0h, expected no load result", rdata);
                end else begin
                    checkOutput("rd_data", 32'(rdata), 32'(rdQ.pop_front()));
                end
            end
        end
    end

    task automatic stopHung(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got no completion, expected completion within bound", name);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] aborted");
    endtask

    // One legal access with w bus wait cycles; flags stay up through DONE like the pipeline holds them.
    task automatic applyStimulus(input bit isLoad, input logic [15:0] a, input logic [15:0] d,
                                 input logic [1:0] bs, input int w);
        int      stallCycles;
        bit      released;
        busExp_t e;
        @(negedge clk);
        memRd_flg = isLoad;
        memWrt_flg = !isLoad;
        addr = a;
        wdata = d;
        byte_sel = bs;
        nextWait = w;
        e.we = !isLoad;
        e.addr = a;
        e.wdata = d;
        e.be = isLoad ? 2'b11 : bs;
        busQ.push_back(e);
        if (isLoad) begin
            expRdata = refRead(a);
            rdQ.push_back(expRdata);
        end else begin
            refWrite(a, d, bs);
        end
        #1;
        checkOutput("stall_issue", 32'(stall_flg), 32'(1));
        stallCycles = 1;
        released = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (stall_flg !== 1'b1) begin
                released = 1'b1;
                break;
            end
            stallCycles++;
        end
        if (!released) stopHung("stall_release");
        checkOutput("stall_cycles", stallCycles, 2 + w);
        checkOutput("done_rd_valid", 32'(rd_valid), 32'(isLoad));
        checkOutput("done_rdata", 32'(rdata), 32'(expRdata));
        checkOutput("acc_err", 32'(acc_err), 32'(expErr));
    endtask

    task automatic applyIllegal(input bit both);
        @(negedge clk);
        memRd_flg = both;
        memWrt_flg = 1'b1;
        byte_sel = both ? 2'b11 : 2'b00;
        addr = 16'($urandom);
        wdata = 16'($urandom);
        expErr = 1'b1;
        #1;
        if (both) checkOutput("illegal_stall", 32'(stall_flg), 32'(0));
        @(negedge clk);
        checkOutput("illegal_err", 32'(acc_err), 32'(expErr));
        checkOutput("illegal_no_req", 32'(mem_req), 32'(0));
        memRd_flg = 1'b0;
        memWrt_flg = 1'b0;
    endtask

    task automatic applyIdle(input int n);
        @(negedge clk);
        memRd_flg = 1'b0;
        memWrt_flg = 1'b0;
        #1;
        checkOutput("idle_stall", 32'(stall_flg), 32'(0));
        repeat (n) @(negedge clk);
        checkOutput("idle_no_req", 32'(mem_req), 32'(0));
    endtask

    task automatic runRandom(input int count);
        int          kind;
        logic [15:0] a;
        for (int n = 0; n < count; n++) begin
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 7));
            if (kind < 4) begin
                applyStimulus(1'b1, a, 16'($urandom), 2'b11, $urandom_range(0, 4));
            end else if (kind < 8) begin
                applyStimulus(1'b0, a, 16'($urandom), 2'($urandom_range(1, 3)), $urandom_range(0, 4));
            end else if (kind == 8) begin
                applyIdle($urandom_range(0, 3));
            end else begin
                applyIllegal(1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'(0));
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        checkOutput({tag, "_mem_be"}, 32'(mem_be), 32'(0));
        checkOutput({tag, "_rdata"}, 32'(rdata), 32'(0));
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
        checkOutput({tag, "_acc_err"}, 32'(acc_err), 32'(0));
        checkOutput({tag, "_stall"}, 32'(stall_flg), 32'(0));
    endtask

    task automatic resetMidBus();
        busExp_t e;
        manualBus = 1'b1;
        @(negedge clk);
        memRd_flg = 1'b1;
        memWrt_flg = 1'b0;
        addr = 16'h0BAD;
        byte_sel = 2'b11;
        e.we = 1'b0;
        e.addr = 16'h0BAD;
        e.wdata = wdata;
        e.be = 2'b11;
        busQ.push_back(e);
        @(negedge clk);
        checkOutput("rst_pre_req", 32'(mem_req), 32'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_low_stall", 32'(stall_flg), 32'(0));
        @(negedge clk);
        checkResetOutputs("rst_mid");
        rst_n = 1'b1;
        memRd_flg = 1'b0;
        expErr = 1'b0;
        expRdata = 16'h0;
        strayReq++;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stray_rd_valid", 32'(rd_valid), 32'(0));
            checkOutput("stray_mem_req", 32'(mem_req), 32'(0));
        end
        manualBus = 1'b0;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic timeoutTest();
        busExp_t e;
        int      reqCycles;
        bit      dropped;
        manualBus = 1'b1;
        @(negedge clk);
        memRd_flg = 1'b1;
        memWrt_flg = 1'b0;
        addr = 16'h0C0D;
        byte_sel = 2'b11;
        e.we = 1'b0;
        e.addr = 16'h0C0D;
        e.wdata = wdata;
        e.be = 2'b11;
        busQ.push_back(e);
        expErr = 1'b1;
        reqCycles = 0;
        dropped = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1) begin
                dropped = 1'b1;
                break;
            end
            reqCycles++;
        end
        if (!dropped) stopHung("tmo_drop");
        checkOutput("tmo_req_cycles", reqCycles, TMO);
        checkOutput("tmo_stall", 32'(stall_flg), 32'(0));
        checkOutput("tmo_rd_valid", 32'(rd_valid), 32'(0));
        checkOutput("tmo_acc_err", 32'(acc_err), 32'(1));
        checkOutput("tmo_rdata", 32'(rdata), 32'(expRdata));
        manualBus = 1'b0;
    endtask
`endif

    initial begin : watchdog
        #500000;
        stopHung("global_time");
    end

    initial begin : driver
        refMem[16'h0040] = 16'hBEEF;
        busMem[16'h0040] = 16'hBEEF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        applyStimulus(1'b1, 16'h0040, 16'h0000, 2'b00, 0);
        applyStimulus(1'b0, 16'h0102, 16'hA500, 2'b10, 3);
        applyStimulus(1'b1, 16'h0102, 16'h0000, 2'b11, 1);
        applyStimulus(1'b0, 16'h0102, 16'h12C3, 2'b01, 0);
        applyStimulus(1'b1, 16'h0102, 16'h0000, 2'b11, 2);
        applyStimulus(1'b1, 16'h0040, 16'h0000, 2'b11, 0);
        applyIdle(2);
        applyIllegal(1'b1);
        applyStimulus(1'b1, 16'h0040, 16'h0000, 2'b11, 1);
        applyIllegal(1'b0);

        runRandom(80);
        applyIdle(2);
        resetMidBus();
        applyStimulus(1'b0, 16'h0007, 16'h5A5A, 2'b11, 0);
        applyStimulus(1'b1, 16'h0007, 16'h0000, 2'b11, 0);
`ifdef MEM_TIMEOUT_EN
        timeoutTest();
`endif
        applyIdle(3);
        checkOutput("busq_drained", busQ.size(), 0);
        checkOutput("rdq_drained", rdQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
